// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared constants for the ALU issue/writeback controller: supported opcodes,
// supported R-type funct codes, FSM state encodings and the immediate
// sign-extension helper.
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

   // Opcodes handled by the controller
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // R-type funct codes handled by the controller
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;

   // 16-bit immediate to 32-bit two's complement value
   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Purely combinational split of a 32-bit instruction into its fields, the
// sign-extended immediate, instruction class flags and a legality flag.
// Ports:
//   i_instr     : instruction word
//   o_opcode    : [31:26]        o_rs : [25:21]     o_rt : [20:16]
//   o_rd        : [15:11]        o_funct : [5:0]
//   o_imm_sext  : sign-extended [15:0]
//   o_legal     : opcode (and funct for R-type) is supported
//   o_is_rtype / o_is_lw / o_is_sw / o_is_beq : instruction class
// -----------------------------------------------------------------------------
module instr_field_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [5:0]  o_opcode,
   output logic [4:0]  o_rs,
   output logic [4:0]  o_rt,
   output logic [4:0]  o_rd,
   output logic [5:0]  o_funct,
   output logic [31:0] o_imm_sext,
   output logic        o_legal,
   output logic        o_is_rtype,
   output logic        o_is_lw,
   output logic        o_is_sw,
   output logic        o_is_beq
);

   assign o_opcode   = i_instr[31:26];
   assign o_rs       = i_instr[25:21];
   assign o_rt       = i_instr[20:16];
   assign o_rd       = i_instr[15:11];
   assign o_funct    = i_instr[5:0];
   assign o_imm_sext = sext16(i_instr[15:0]);

   // Class flags and legality; R-type is only legal for the four ALU functs
   always_comb begin
      o_legal    = 1'b0;
      o_is_rtype = 1'b0;
      o_is_lw    = 1'b0;
      o_is_sw    = 1'b0;
      o_is_beq   = 1'b0;
      case (i_instr[31:26])
         OP_RTYPE: begin
            o_is_rtype = 1'b1;
            case (i_instr[5:0])
               FN_ADD, FN_SUB, FN_AND, FN_OR: o_legal = 1'b1;
               default:                       o_legal = 1'b0;
            endcase
         end
         OP_LW: begin
            o_is_lw = 1'b1;
            o_legal = 1'b1;
         end
         OP_SW: begin
            o_is_sw = 1'b1;
            o_legal = 1'b1;
         end
         OP_BEQ: begin
            o_is_beq = 1'b1;
            o_legal  = 1'b1;
         end
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Multi-cycle issue/writeback controller: accepts one instruction over a
// valid/ready handshake, reads the register file, drives the ALU, then performs
// a memory access, a register writeback or reports a BEQ outcome.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   i_instr_valid/o_instr_ready/i_instr : instruction handshake
//   o_rf_raddr1/2, i_rf_rdata1/2     : combinational-read register file
//   o_rf_we/o_rf_waddr/o_rf_wdata    : register writeback
//   o_alu_opcode/funct/in1/in2, i_alu_result : ALU drive and return
//   o_mem_req/we/addr/wdata, i_mem_rdata, i_mem_ack : data memory
//   o_branch_valid/taken/offset      : BEQ outcome
//   o_illegal                        : one-cycle unsupported-instruction pulse
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_instr_valid,
   output logic        o_instr_ready,
   input  logic [31:0] i_instr,
   output logic [4:0]  o_rf_raddr1,
   output logic [4:0]  o_rf_raddr2,
   input  logic [31:0] i_rf_rdata1,
   input  logic [31:0] i_rf_rdata2,
   output logic        o_rf_we,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic [5:0]  o_alu_opcode,
   output logic [5:0]  o_alu_funct,
   output logic [31:0] o_alu_in1,
   output logic [31:0] o_alu_in2,
   input  logic [31:0] i_alu_result,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ack,
   output logic        o_branch_valid,
   output logic        o_branch_taken,
   output logic [31:0] o_branch_offset,
   output logic        o_illegal
);

   logic [2:0]  r_state;
   logic [31:0] r_instr;
   logic [31:0] r_a;
   logic [31:0] r_b;

   logic [5:0]  w_opcode;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [5:0]  w_funct;
   logic [31:0] w_imm_sext;
   logic        w_legal;
   logic        w_is_rtype;
   logic        w_is_lw;
   logic        w_is_sw;
   logic        w_is_beq;

   instr_field_decode u_decode (
      .i_instr    (r_instr),
      .o_opcode   (w_opcode),
      .o_rs       (w_rs),
      .o_rt       (w_rt),
      .o_rd       (w_rd),
      .o_funct    (w_funct),
      .o_imm_sext (w_imm_sext),
      .o_legal    (w_legal),
      .o_is_rtype (w_is_rtype),
      .o_is_lw    (w_is_lw),
      .o_is_sw    (w_is_sw),
      .o_is_beq   (w_is_beq)
   );

   // Register-file read addresses: the file reads combinationally, so the
   // addresses follow DECODE directly and the data is captured at its end
   always_comb begin
      if (r_state == ST_DECODE) begin
         o_rf_raddr1 = w_rs;
         o_rf_raddr2 = w_rt;
      end else begin
         o_rf_raddr1 = 5'd0;
         o_rf_raddr2 = 5'd0;
      end
   end

   // FSM plus registered outputs: each transition loads the outputs that
   // belong to the state being entered and clears those of the state left
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_instr         <= 32'd0;
         r_a             <= 32'd0;
         r_b             <= 32'd0;
         o_instr_ready   <= 1'b1;
         o_rf_we         <= 1'b0;
         o_rf_waddr      <= 5'd0;
         o_rf_wdata      <= 32'd0;
         o_alu_opcode    <= 6'd0;
         o_alu_funct     <= 6'd0;
         o_alu_in1       <= 32'd0;
         o_alu_in2       <= 32'd0;
         o_mem_req       <= 1'b0;
         o_mem_we        <= 1'b0;
         o_mem_addr      <= 32'd0;
         o_mem_wdata     <= 32'd0;
         o_branch_valid  <= 1'b0;
         o_branch_taken  <= 1'b0;
         o_branch_offset <= 32'd0;
         o_illegal       <= 1'b0;
      end else begin
         o_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_instr_valid && o_instr_ready) begin
                  r_instr       <= i_instr;
                  o_instr_ready <= 1'b0;
                  r_state       <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_a <= i_rf_rdata1;
               r_b <= i_rf_rdata2;
               if (w_legal) begin
                  r_state      <= ST_EXEC;
                  o_alu_opcode <= w_opcode;
                  // loads/stores reuse the ALU adder for address generation
                  o_alu_funct  <= (w_is_lw || w_is_sw) ? FN_ADD : w_funct;
                  o_alu_in1    <= i_rf_rdata1;
                  o_alu_in2    <= (w_is_lw || w_is_sw) ? w_imm_sext : i_rf_rdata2;
               end else begin
                  o_illegal     <= 1'b1;
                  o_instr_ready <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               o_alu_opcode <= 6'd0;
               o_alu_funct  <= 6'd0;
               o_alu_in1    <= 32'd0;
               o_alu_in2    <= 32'd0;
               if (w_is_rtype) begin
                  o_rf_we    <= (w_rd != 5'd0);
                  o_rf_waddr <= w_rd;
                  o_rf_wdata <= i_alu_result;
                  r_state    <= ST_WB;
               end else if (w_is_lw || w_is_sw) begin
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= w_is_sw;
                  o_mem_addr  <= i_alu_result;
                  o_mem_wdata <= r_b;
                  r_state     <= ST_MEM;
               end else if (w_is_beq) begin
                  // equality from the captured operands, not from the ALU
                  o_branch_valid  <= 1'b1;
                  o_branch_taken  <= (r_a == r_b);
                  o_branch_offset <= {w_imm_sext[29:0], 2'b00};
                  r_state         <= ST_WB;
               end else begin
                  o_instr_ready <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            ST_MEM: begin
               if (i_mem_ack) begin
                  o_mem_req   <= 1'b0;
                  o_mem_we    <= 1'b0;
                  o_mem_addr  <= 32'd0;
                  o_mem_wdata <= 32'd0;
                  if (w_is_lw) begin
                     o_rf_we    <= (w_rt != 5'd0);
                     o_rf_waddr <= w_rt;
                     o_rf_wdata <= i_mem_rdata;
                     r_state    <= ST_WB;
                  end else begin
                     o_instr_ready <= 1'b1;
                     r_state       <= ST_IDLE;
                  end
               end
            end
            ST_WB: begin
               o_rf_we         <= 1'b0;
               o_rf_waddr      <= 5'd0;
               o_rf_wdata      <= 32'd0;
               o_branch_valid  <= 1'b0;
               o_branch_taken  <= 1'b0;
               o_branch_offset <= 32'd0;
               o_instr_ready   <= 1'b1;
               r_state         <= ST_IDLE;
            end
            default: begin
               o_instr_ready <= 1'b1;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl. A transaction-level model turns each
// issued instruction into the list of output values expected on each cycle
// from the accept cycle onward; one compare process checks every output
// against that list on every falling edge (idle values when the list is
// empty). A few literal checks pin the model to hand-computed results.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_instr_valid = 1'b0;
   logic        o_instr_ready;
   logic [31:0] i_instr = 32'd0;
   logic [4:0]  o_rf_raddr1, o_rf_raddr2;
   logic [31:0] i_rf_rdata1, i_rf_rdata2;
   logic        o_rf_we;
   logic [4:0]  o_rf_waddr;
   logic [31:0] o_rf_wdata;
   logic [5:0]  o_alu_opcode, o_alu_funct;
   logic [31:0] o_alu_in1, o_alu_in2;
   logic [31:0] i_alu_result;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic        i_mem_ack;
   logic        o_branch_valid, o_branch_taken;
   logic [31:0] o_branch_offset;
   logic        o_illegal;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready), .i_instr(i_instr),
      .o_rf_raddr1(o_rf_raddr1), .o_rf_raddr2(o_rf_raddr2),
      .i_rf_rdata1(i_rf_rdata1), .i_rf_rdata2(i_rf_rdata2),
      .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
      .o_alu_opcode(o_alu_opcode), .o_alu_funct(o_alu_funct),
      .o_alu_in1(o_alu_in1), .o_alu_in2(o_alu_in2), .i_alu_result(i_alu_result),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
      .o_branch_valid(o_branch_valid), .o_branch_taken(o_branch_taken),
      .o_branch_offset(o_branch_offset), .o_illegal(o_illegal)
   );

   always #5 clk = ~clk;

   // ---------------- environment: register file, ALU, memory ----------------
   logic [31:0] env_rf [32];
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_idx = 5'd0;
   logic [31:0] cfg_val = 32'd0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) env_rf[i] <= 32'd0;
      end else if (cfg_we) begin
         env_rf[cfg_idx] <= cfg_val;
      end else if (o_rf_we) begin
         env_rf[o_rf_waddr] <= o_rf_wdata;
      end
   end

   assign i_rf_rdata1 = env_rf[o_rf_raddr1];
   assign i_rf_rdata2 = env_rf[o_rf_raddr2];

   always_comb begin
      case (o_alu_funct)
         6'd32:   i_alu_result = o_alu_in1 + o_alu_in2;
         6'd34:   i_alu_result = o_alu_in1 - o_alu_in2;
         6'd36:   i_alu_result = o_alu_in1 & o_alu_in2;
         6'd37:   i_alu_result = o_alu_in1 | o_alu_in2;
         default: i_alu_result = 32'd0;
      endcase
   end

   assign i_mem_rdata = o_mem_addr ^ 32'hDEAD_0000;

   int   ack_delay = 0;
   logic ack_resp  = 1'b0;
   logic stray_ack = 1'b0;
   assign i_mem_ack = ack_resp | stray_ack;

   // memory responder: ack after ack_delay cycles of mem_req
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !o_mem_req) begin
            ack_resp = 1'b0;
            cnt = 0;
         end else begin
            ack_resp = (cnt == ack_delay);
            cnt++;
         end
      end
   end

   int          mem_writes = 0;
   logic [31:0] last_wr_addr = 32'd0;
   logic [31:0] last_wr_data = 32'd0;
   logic        last_bt = 1'b0;
   logic [31:0] last_boff = 32'd0;
   int          cyc = 0;
   int          we_cyc = 0;
   int          acc_cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_mem_req && o_mem_we && i_mem_ack) begin
         mem_writes   <= mem_writes + 1;
         last_wr_addr <= o_mem_addr;
         last_wr_data <= o_mem_wdata;
      end
      if (o_branch_valid) begin
         last_bt   <= o_branch_taken;
         last_boff <= o_branch_offset;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (o_rf_we) we_cyc = cyc;
      end
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;
   bit done   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        ready;
      logic [4:0]  ra1, ra2;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [5:0]  aop, afn;
      logic [31:0] in1, in2;
      logic        mreq, mwe;
      logic [31:0] maddr, mwdata;
      logic        bv, bt;
      logic [31:0] boff;
      logic        ill;
   } vec_t;

   vec_t        q[$];
   logic [31:0] ref_rf [32];

   function automatic vec_t idle_vec();
      vec_t v;
      v = '0;
      v.ready = 1'b1;
      return v;
   endfunction

   // Model: expected outputs per cycle, cycle 0 = accept cycle
   task automatic push_trace(input logic [31:0] ins, input int d);
      vec_t        v;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, se, res, addr;
      logic        legal, is_mem;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      se = {{16{ins[15]}}, ins[15:0]};
      a = ref_rf[rs]; b = ref_rf[rt];
      q.push_back(idle_vec());
      v = '0; v.ra1 = rs; v.ra2 = rt;
      q.push_back(v);
      legal = (op == 6'd0 && (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37))
              || op == 6'd35 || op == 6'd43 || op == 6'd4;
      if (!legal) begin
         v = idle_vec(); v.ill = 1'b1;
         q.push_back(v);
         return;
      end
      is_mem = (op == 6'd35 || op == 6'd43);
      v = '0; v.aop = op; v.afn = is_mem ? 6'd32 : fn; v.in1 = a; v.in2 = is_mem ? se : b;
      q.push_back(v);
      if (op == 6'd0) begin
         res = (fn == 6'd32) ? a + b : (fn == 6'd34) ? a - b : (fn == 6'd36) ? (a & b) : (a | b);
         v = '0; v.rf_we = (rd != 5'd0); v.waddr = rd; v.wdata = res;
         q.push_back(v);
         if (rd != 5'd0) ref_rf[rd] = res;
      end else if (op == 6'd4) begin
         v = '0; v.bv = 1'b1; v.bt = (a == b); v.boff = se * 32'd4;
         q.push_back(v);
      end else begin
         addr = a + se;
         for (int i = 0; i <= d; i++) begin
            v = '0; v.mreq = 1'b1; v.mwe = (op == 6'd43); v.maddr = addr; v.mwdata = b;
            q.push_back(v);
         end
         if (op == 6'd35) begin
            v = '0; v.rf_we = (rt != 5'd0); v.waddr = rt; v.wdata = addr ^ 32'hDEAD_0000;
            q.push_back(v);
            if (rt != 5'd0) ref_rf[rt] = addr ^ 32'hDEAD_0000;
         end
      end
   endtask

   // compare process: every output on every falling edge
   initial begin
      vec_t e;
      while (!done) begin
         @(negedge clk);
         if (q.size() != 0) e = q.pop_front();
         else e = idle_vec();
         chk("instr_ready",   32'(o_instr_ready),   32'(e.ready));
         chk("rf_raddr1",     32'(o_rf_raddr1),     32'(e.ra1));
         chk("rf_raddr2",     32'(o_rf_raddr2),     32'(e.ra2));
         chk("rf_we",         32'(o_rf_we),         32'(e.rf_we));
         chk("rf_waddr",      32'(o_rf_waddr),      32'(e.waddr));
         chk("rf_wdata",      o_rf_wdata,           e.wdata);
         chk("alu_opcode",    32'(o_alu_opcode),    32'(e.aop));
         chk("alu_funct",     32'(o_alu_funct),     32'(e.afn));
         chk("alu_in1",       o_alu_in1,            e.in1);
         chk("alu_in2",       o_alu_in2,            e.in2);
         chk("mem_req",       32'(o_mem_req),       32'(e.mreq));
         chk("mem_we",        32'(o_mem_we),        32'(e.mwe));
         chk("mem_addr",      o_mem_addr,           e.maddr);
         chk("mem_wdata",     o_mem_wdata,          e.mwdata);
         chk("branch_valid",  32'(o_branch_valid),  32'(e.bv));
         chk("branch_taken",  32'(o_branch_taken),  32'(e.bt));
         chk("branch_offset", o_branch_offset,      e.boff);
         chk("illegal",       32'(o_illegal),       32'(e.ill));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
      @(posedge clk); #2;
      cfg_we = 1'b1; cfg_idx = idx; cfg_val = val;
      ref_rf[idx] = val;
      @(posedge clk); #2;
      cfg_we = 1'b0;
   endtask

   task automatic start_instr(input logic [31:0] ins, input int d);
      @(posedge clk); #2;
      ack_delay = d;
      i_instr = ins; i_instr_valid = 1'b1;
      acc_cyc = cyc;
      push_trace(ins, d);
      @(posedge clk); #2;
      i_instr_valid = 1'b0;
      i_instr = $urandom;
   endtask

   task automatic wait_done(input string name);
      for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
      if (q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s_timeout: %0d expected cycles left, required 0", name, q.size());
         q.delete();
      end
      @(posedge clk);
   endtask

   task automatic run(input string name, input logic [31:0] ins, input int d);
      start_instr(ins, d);
      wait_done(name);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);

      set_reg(5'd1, 32'd5);
      set_reg(5'd2, 32'd7);

      // ADD r3,r1,r2 with a stray ack that must be ignored
      stray_ack = 1'b1;
      run("add", {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 0);
      stray_ack = 1'b0;
      chk("add_we_cycle", 32'(we_cyc - acc_cyc), 32'd3);
      chk("add_r3_env",   env_rf[3], 32'd12);
      chk("add_r3_model", ref_rf[3], 32'd12);

      run("sub_r0", {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100010}, 0);
      chk("sub_r0_env", env_rf[0], 32'd0);
      run("and", {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100100}, 0);
      chk("and_r5_env", env_rf[5], 32'd5);
      run("or",  {6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'b100101}, 0);
      chk("or_r6_env", env_rf[6], 32'd7);

      // LW r4,-4(r1) with ack three cycles late
      set_reg(5'd1, 32'h0000_0100);
      set_reg(5'd2, 32'h0000_0100);
      run("lw", {6'b100011, 5'd1, 5'd4, 16'hFFFC}, 3);
      chk("lw_r4_env", env_rf[4], 32'hDEAD_00FC);

      // BEQ r1,r2,-1: equal then unequal
      run("beq_eq", {6'b000100, 5'd1, 5'd2, 16'hFFFF}, 0);
      chk("beq_eq_taken",  32'(last_bt), 32'd1);
      chk("beq_eq_offset", last_boff, 32'hFFFF_FFFC);
      set_reg(5'd2, 32'h0000_0200);
      run("beq_ne", {6'b000100, 5'd1, 5'd2, 16'hFFFF}, 0);
      chk("beq_ne_taken", 32'(last_bt), 32'd0);

      // SW r2,8(r1) with immediate ack, then LW r7,8(r1) ack immediate
      run("sw", {6'b101011, 5'd1, 5'd2, 16'd8}, 0);
      chk("sw_count", 32'(mem_writes), 32'd1);
      chk("sw_addr",  last_wr_addr, 32'h0000_0108);
      chk("sw_data",  last_wr_data, 32'h0000_0200);
      run("lw_fast", {6'b100011, 5'd1, 5'd7, 16'd8}, 0);

      // illegal opcode, and R-type with unsupported funct
      run("ill_op",    {6'b111111, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 0);
      run("ill_funct", {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'b000000}, 0);
      chk("ill_no_write", env_rf[9], 32'd0);

      // reset during MEM of an SW
      start_instr({6'b101011, 5'd1, 5'd2, 16'd4}, 20);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk("rst_mem_req",     32'(o_mem_req),     32'd0);
      chk("rst_instr_ready", 32'(o_instr_ready), 32'd1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      ack_delay = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_after", 32'(o_instr_ready), 32'd1);
      chk("rst_no_mem_write", 32'(mem_writes), 32'd1);

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
